ram_responder: RTL

Memory-side responder for the processor's RAM strobes (Ram_Inst_Read, Ram_Data_Read, Ram_Data_Write). It arbitrates the strobes, inserts configurable wait states, commits exactly one access per strobe assertion, and returns registered instruction/data words with a one-cycle Ram_Ready pulse. It sits between the controller/datapath and the storage array.

---
 rtl/ram_responder_pkg.sv | 29 ++
 rtl/ram_responder_array.sv | 25 ++
 rtl/ram_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ram_responder_pkg.sv
// rtl/ram_responder_pkg.sv - shared encodings and defaults for the RAM responder
package ram_responder_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        RAM_IDLE    = 2'd0,
        RAM_BUSY    = 2'd1,
        RAM_RELEASE = 2'd2
    } ram_state_e;

    typedef enum logic [1:0] {
        REQ_INST  = 2'd0,
        REQ_DREAD = 2'd1,
        REQ_WRITE = 2'd2
    } req_kind_e;

    // Fixed priority among simultaneous strobes: write, then data read, then instruction read.
    function automatic req_kind_e pick_kind(input logic wr, input logic dr);
        if (wr) begin
            return REQ_WRITE;
        end else if (dr) begin
            return REQ_DREAD;
        end
        return REQ_INST;
    endfunction

endpackage

// File: rtl/ram_responder_array.sv
// rtl/ram_responder_array.sv - DEPTH x DATA_WIDTH storage, synchronous write, combinational read
module ram_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the caller only enables writes for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - strobe arbiter, wait-state sequencer and output registers for the RAM
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Ram_Inst_Read,
    input  logic                  Ram_Data_Read,
    input  logic                  Ram_Data_Write,
    input  logic [ADDR_WIDTH-1:0] Ram_Addr,
    input  logic [DATA_WIDTH-1:0] Ram_Data_In,
    output logic [DATA_WIDTH-1:0] Ram_Inst_Out,
    output logic [DATA_WIDTH-1:0] Ram_Data_Out,
    output logic                  Ram_Ready,
    output logic                  Ram_Busy,
    output logic                  Ram_Err
);

    localparam logic [3:0]          WS_W    = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    ram_state_e            state_q, state_d;
    req_kind_e             kind_q, kind_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] inst_out_q, inst_out_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  in_rel, wr_m, dr_m, ir_m, any_req, can_accept;
    logic                  served_high, in_range, commit, mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata, read_val;

    // In RELEASE the strobe just served is still high; mask it so only a different strobe starts a new request.
    assign in_rel      = (state_q == RAM_RELEASE);
    assign wr_m        = Ram_Data_Write & ~(in_rel & (kind_q == REQ_WRITE));
    assign dr_m        = Ram_Data_Read  & ~(in_rel & (kind_q == REQ_DREAD));
    assign ir_m        = Ram_Inst_Read  & ~(in_rel & (kind_q == REQ_INST));
    assign any_req     = wr_m | dr_m | ir_m;
    assign can_accept  = (state_q == RAM_IDLE) | in_rel;
    assign served_high = (kind_q == REQ_WRITE) ? Ram_Data_Write :
                         (kind_q == REQ_DREAD) ? Ram_Data_Read  : Ram_Inst_Read;

    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign commit   = (state_q == RAM_BUSY) && (cnt_q == WS_W);
    assign mem_we   = commit && (kind_q == REQ_WRITE) && in_range;
    assign read_val = in_range ? mem_rdata : '0;

    ram_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk  (Clk),
        .we   (mem_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    // Next-state logic: accept, count wait states, commit once, then wait for the served strobe to drop.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        inst_out_d = inst_out_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            RAM_IDLE: begin
            end
            RAM_BUSY: begin
                if (commit) begin
                    state_d = RAM_RELEASE;
                    ready_d = 1'b1;
                    err_d   = ~in_range;
                    if (kind_q == REQ_INST) begin
                        inst_out_d = read_val;
                    end else if (kind_q == REQ_DREAD) begin
                        data_out_d = read_val;
                    end
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    busy_d = 1'b1;
                end
            end
            RAM_RELEASE: begin
                if (!served_high) begin
                    state_d = RAM_IDLE;
                end
            end
            default: state_d = RAM_IDLE;
        endcase

        if (can_accept && any_req) begin
            state_d = RAM_BUSY;
            kind_d  = pick_kind(wr_m, dr_m);
            addr_d  = Ram_Addr;
            wdata_d = Ram_Data_In;
            cnt_d   = 4'd0;
            err_d   = wr_m & (dr_m | ir_m);
        end
    end

    // FSM state, latched request and registered outputs; reset aborts any request in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= RAM_IDLE;
            kind_q     <= REQ_INST;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= 4'd0;
            inst_out_q <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            inst_out_q <= inst_out_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign Ram_Inst_Out = inst_out_q;
    assign Ram_Data_Out = data_out_q;
    assign Ram_Ready    = ready_q;
    assign Ram_Busy     = busy_q;
    assign Ram_Err      = err_q;

endmodule
